regfile_param: RTL and testbench

- Parametrised successor to the MIPS-32 two-read/one-write register file.
- Data width and address width are configurable.
- Adds a hardware clear sequence that zeroes every register after reset.
- Adds a per-register pending-write scoreboard, so the pipeline can detect read-after-write hazards on in-flight loads and multi-cycle results.
- Sits between decode (read ports, Claim) and write-back (write port).

---
 rtl/regfile_param.sv | 137 +++++++++++++
 tb/tb_regfile_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with a post-reset clear sweep and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN adds write-through forwarding from the write port to both read ports.
module regfile_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Read_Reg1,
    input  logic [ADDR_WIDTH-1:0] Read_Reg2,
    output logic [DATA_WIDTH-1:0] Read_Data1,
    output logic [DATA_WIDTH-1:0] Read_Data2,
    input  logic [ADDR_WIDTH-1:0] Write_Reg,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  RegWrite,
    input  logic                  Claim,
    input  logic [ADDR_WIDTH-1:0] Claim_Reg,
    output logic                  Stall1,
    output logic                  Stall2,
    output logic                  Busy
);

    localparam int unsigned DEPTH   = 32'd1 << ADDR_WIDTH;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    clr_last;
    logic                    run;
    logic                    wr_en;
    logic                    claim_en;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]        pending;

    logic [ADDR_WIDTH-1:0]   rd_addr  [2];
    logic [DATA_WIDTH-1:0]   rd_data  [2];
    logic                    rd_stall [2];

    assign run      = (state == ST_RUN);
    assign clr_last = (clr_cnt == ADDR_WIDTH'(DEPTH - 1));

    // Writes and claims only act in RUN; register 0 is inert when hardwired.
    assign wr_en    = run && !reset && RegWrite && !(ZERO_EN && (Write_Reg == '0));
    assign claim_en = run && !reset && Claim    && !(ZERO_EN && (Claim_Reg == '0));

    // State register
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: sweep once, then stay in RUN until reset
    always_comb begin
        next_state = state;
        case (state)
            ST_CLEAR: if (clr_last) next_state = ST_RUN;
            ST_RUN:   next_state = ST_RUN;
            default:  next_state = ST_CLEAR;
        endcase
    end

    // Clear sweep counter
    always_ff @(posedge Clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
        end
    end

    // Register array: sweep zeroes one entry per cycle, otherwise the write port
    always_ff @(posedge Clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                regs[clr_cnt] <= '0;
            end else if (wr_en) begin
                regs[Write_Reg] <= Write_Data;
            end
        end
    end

    // Scoreboard: a claim is applied after the write so it wins on the same register
    always_ff @(posedge Clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (wr_en) begin
                pending[Write_Reg] <= 1'b0;
            end
            if (claim_en) begin
                pending[Claim_Reg] <= 1'b1;
            end
        end
    end

    assign rd_addr[0] = Read_Reg1;
    assign rd_addr[1] = Read_Reg2;

    // Combinational read ports; everything reads as zero while the sweep runs
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p]  = '0;
            rd_stall[p] = 1'b0;
            if (run && !(ZERO_EN && (rd_addr[p] == '0))) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (Write_Reg == rd_addr[p])) begin
                    rd_data[p]  = Write_Data;
                    rd_stall[p] = claim_en && (Claim_Reg == rd_addr[p]);
                end else begin
                    rd_data[p]  = regs[rd_addr[p]];
                    rd_stall[p] = pending[rd_addr[p]];
                end
`else
                rd_data[p]  = regs[rd_addr[p]];
                rd_stall[p] = pending[rd_addr[p]];
`endif
            end
        end
    end

    assign Read_Data1 = rd_data[0];
    assign Read_Data2 = rd_data[1];
    assign Stall1     = rd_stall[0];
    assign Stall2     = rd_stall[1];
    assign Busy       = (state == ST_CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Randomised and directed bench for regfile_param against a behavioural register-file model.
module tb_regfile_param;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
    localparam bit ZR   = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP  = 1'b1;
`else
    localparam bit BYP  = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Read_Reg1, Read_Reg2, Write_Reg, Claim_Reg;
    logic [DW-1:0] Read_Data1, Read_Data2, Write_Data;
    logic          RegWrite, Claim, Stall1, Stall2, Busy;

    always #5 Clk = ~Clk;

    regfile_param #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ZERO_REG  (1)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .Read_Reg1 (Read_Reg1),
        .Read_Reg2 (Read_Reg2),
        .Read_Data1(Read_Data1),
        .Read_Data2(Read_Data2),
        .Write_Reg (Write_Reg),
        .Write_Data(Write_Data),
        .RegWrite  (RegWrite),
        .Claim     (Claim),
        .Claim_Reg (Claim_Reg),
        .Stall1    (Stall1),
        .Stall2    (Stall2),
        .Busy      (Busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain arrays plus the number of sweep cycles still to run
    logic [DW-1:0] m_regs [NREG];
    bit            m_pend [NREG];
    int            m_clear_left = 0;
    bit            m_valid      = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_zero(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    function automatic bit fwd_hit(input logic [AW-1:0] a);
        return BYP && !reset && RegWrite && (Write_Reg == a);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (m_clear_left > 0 || is_zero(a)) return '0;
        if (fwd_hit(a)) return Write_Data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall(input logic [AW-1:0] a);
        if (m_clear_left > 0 || is_zero(a)) return 1'b0;
        if (fwd_hit(a)) return Claim && (Claim_Reg == a);
        return m_pend[a];
    endfunction

    task automatic drive(input logic rst, input int r1, input int r2, input logic we,
                         input int wr, input logic [DW-1:0] wd, input logic cl, input int cr);
        reset      = rst;
        Read_Reg1  = AW'(r1);
        Read_Reg2  = AW'(r2);
        RegWrite   = we;
        Write_Reg  = AW'(wr);
        Write_Data = wd;
        Claim      = cl;
        Claim_Reg  = AW'(cr);
    endtask

    // Compare outputs mid-cycle, take the edge, then advance the model by the spec rules
    task automatic cycle();
        #1;
        if (m_valid) begin
            check("busy",   Busy,       m_clear_left > 0);
            check("rdata1", Read_Data1, exp_data(Read_Reg1));
            check("rdata2", Read_Data2, exp_data(Read_Reg2));
            check("stall1", Stall1,     exp_stall(Read_Reg1));
            check("stall2", Stall2,     exp_stall(Read_Reg2));
        end
        @(posedge Clk);
        if (reset) begin
            m_valid      = 1'b1;
            m_clear_left = NREG;
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else begin
            if (RegWrite && !is_zero(Write_Reg)) begin
                m_regs[Write_Reg] = Write_Data;
                m_pend[Write_Reg] = 1'b0;
            end
            if (Claim && !is_zero(Claim_Reg)) m_pend[Claim_Reg] = 1'b1;
        end
        @(negedge Clk);
    endtask

    // Count Busy cycles (bounded); optionally issue a write to reg 3 at a given sweep cycle
    task automatic run_clear(input int inject_at, output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            drive(1'b0, c % NREG, NREG - 1 - (c % NREG), c == inject_at, 3, 32'hAAAA, 1'b0, 0);
            #1;
            if (Busy !== 1'b1) break;
            n++;
            cycle();
        end
    endtask

    int n_busy;

    initial begin
        drive(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        cycle();

        // Sweep length, dropped write during CLEAR, all registers zero afterwards
        run_clear(5, n_busy);
        check("busy_len", n_busy, 32);
        for (int i = 0; i < NREG; i++) begin
            drive(1'b0, i, (i + 7) % NREG, 1'b0, 0, '0, 1'b0, 0);
            cycle();
        end
        drive(1'b0, 3, 3, 1'b0, 0, '0, 1'b0, 0);
        #1 check("reg3_dropped", Read_Data1, 32'h0);
        cycle();

        // Basic write/read
        drive(1'b0, 0, 0, 1'b1, 1, 56, 1'b0, 0);
        cycle();
        drive(1'b0, 1, 0, 1'b0, 0, '0, 1'b0, 0);
        #1 check("reg1_56", Read_Data1, 56);
        cycle();
        drive(1'b0, 0, 0, 1'b0, 1, 50, 1'b0, 0);
        cycle();
        drive(1'b0, 1, 0, 1'b0, 0, '0, 1'b0, 0);
        #1 check("reg1_kept", Read_Data1, 56);
        cycle();
        drive(1'b0, 0, 0, 1'b1, 2, 20, 1'b0, 0);
        cycle();
        drive(1'b0, 1, 2, 1'b0, 0, '0, 1'b0, 0);
        #1 check("dual_rd1", Read_Data1, 56);
        check("dual_rd2", Read_Data2, 20);
        cycle();

        // Hardwired register 0
        drive(1'b0, 0, 0, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0);
        cycle();
        drive(1'b0, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        #1 check("reg0_data", Read_Data1, 32'h0);
        check("reg0_stall", Stall1, 1'b0);
        cycle();

        // Scoreboard
        drive(1'b0, 0, 7, 1'b0, 0, '0, 1'b1, 7);
        cycle();
        drive(1'b0, 0, 7, 1'b0, 0, '0, 1'b0, 0);
        #1 check("claim7_stall", Stall2, 1'b1);
        cycle();
        drive(1'b0, 0, 7, 1'b1, 7, 32'h1234, 1'b1, 7);
        #1 check("claim_wins_same", Stall2, 1'b1);
        cycle();
        drive(1'b0, 0, 7, 1'b0, 0, '0, 1'b0, 0);
        #1 check("claim_wins_after", Stall2, 1'b1);
        cycle();
        drive(1'b0, 0, 7, 1'b1, 7, 32'h5678, 1'b0, 0);
        cycle();
        drive(1'b0, 0, 7, 1'b0, 0, '0, 1'b0, 0);
        #1 check("release_stall", Stall2, 1'b0);
        check("release_data", Read_Data2, 32'h5678);
        cycle();

        // Same-cycle write/read collision
        drive(1'b0, 0, 0, 1'b1, 9, 32'h11, 1'b0, 0);
        cycle();
        drive(1'b0, 9, 0, 1'b1, 9, 32'h99, 1'b0, 0);
        #1 check("collide_same", Read_Data1, BYP ? 32'h99 : 32'h11);
        cycle();
        drive(1'b0, 9, 0, 1'b0, 0, '0, 1'b0, 0);
        #1 check("collide_next", Read_Data1, 32'h99);
        cycle();

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive(1'b0, $urandom_range(NREG - 1, 0), $urandom_range(NREG - 1, 0),
                  ($urandom_range(1, 0) == 1), $urandom_range(NREG - 1, 0), $urandom,
                  ($urandom_range(9, 0) < 3), $urandom_range(NREG - 1, 0));
            cycle();
        end

        // Reset in the middle of the sweep restarts it
        drive(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        cycle();
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, c, c, 1'b0, 0, '0, 1'b0, 0);
            cycle();
        end
        drive(1'b1, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        cycle();
        run_clear(-1, n_busy);
        check("busy_len_restart", n_busy, 32);

        // Reset in RUN clears data and scoreboard
        drive(1'b0, 0, 0, 1'b1, 4, 32'h77, 1'b1, 4);
        cycle();
        drive(1'b0, 4, 4, 1'b0, 0, '0, 1'b0, 0);
        #1 check("reg4_data", Read_Data1, 32'h77);
        check("reg4_stall", Stall1, 1'b1);
        cycle();
        drive(1'b1, 4, 4, 1'b0, 0, '0, 1'b0, 0);
        cycle();
        run_clear(-1, n_busy);
        check("busy_len_run_reset", n_busy, 32);
        drive(1'b0, 4, 4, 1'b0, 0, '0, 1'b0, 0);
        #1 check("reg4_cleared", Read_Data1, 32'h0);
        check("reg4_unstalled", Stall1, 1'b0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
